wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter MEM_FIFO_DEPTH, default 2, meaning the memory-result buffer depth (power of 2, at least 2).
REQ-002 The module SHALL have parameter STAT_WIDTH, default 16, meaning the statistics counter width.
REQ-003 clk  input  1  clock; one clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid / alu_rd / alu_data  input  1 / INSTR_REG_BITS / WD_SIZE  ALU result; no backpressure.
REQ-006 mem_valid / mem_rd / mem_data  input  1 / INSTR_REG_BITS / WD_SIZE  load result.
REQ-007 mem_ready  output  1  load result accepted when mem_valid && mem_ready.
REQ-008 mul_valid / mul_rd / mul_data  input  1 / INSTR_REG_BITS / WD_SIZE  multiplier result.
REQ-009 mul_ready  output  1  multiplier result accepted when mul_valid && mul_ready.
REQ-010 wr_rd / wr_data  output  INSTR_REG_BITS / WD_SIZE  register-file write port; wr_rd==0 means no write.
REQ-011 wr_src  output  wb_src_e  source of the current write (WB_NONE/WB_ALU/WB_MEM/WB_MUL).
REQ-012 stall_cnt / wb_cnt  output  STAT_WIDTH  statistics counters.

Function
REQ-013 The module SHALL register the write port: a source granted in cycle N appears on wr_rd/wr_data/wr_src in cycle N+1 only.
REQ-014 With no grant in cycle N, the module SHALL drive wr_rd=0, wr_data=0, wr_src=WB_NONE in cycle N+1.
REQ-015 ALU SHALL have absolute priority: alu_valid with alu_rd!=0 always takes the slot.
REQ-016 alu_valid with alu_rd==0 SHALL be discarded and SHALL NOT consume the slot.
REQ-017 Load results SHALL enter a MEM_FIFO_DEPTH-entry FIFO; mem_ready = !fifo_full, registered-state only, with no push while full, even when a pop occurs in the same cycle.
REQ-018 Results with rd==0 SHALL be pushed and popped normally but SHALL produce wr_rd=0, wr_src=WB_NONE.
REQ-019 When the ALU does not take the slot, the slot SHALL go to the FIFO head or the MUL, chosen by a 1-bit round-robin pointer rr (MEM or MUL).
REQ-020 mul_ready SHALL equal !alu_takes && (fifo_empty || rr==MUL), and SHALL NOT depend on mul_valid.
REQ-021 The FIFO head SHALL pop when !alu_takes && !fifo_empty && (!mul_valid || rr==MEM).
REQ-022 After each MEM or MUL grant, rr SHALL point to the other source; rr SHALL be unchanged otherwise.
REQ-023 FIFO pointers SHALL wrap modulo MEM_FIFO_DEPTH, and an occupancy counter SHALL distinguish full from empty.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged.
REQ-025 A push into an empty FIFO SHALL NOT be eligible for pop until the next cycle.

Reset
REQ-026 Reset SHALL be asynchronous on reset_n low and SHALL set wr_rd=0, wr_data=0, wr_src=WB_NONE, FIFO empty (mem_ready=1), rr=MEM, stall_cnt=0, wb_cnt=0.
REQ-027 Reset mid-operation SHALL discard all buffered results, with no write issued after reset deasserts.

Configuration
REQ-028 With WB_STATS_EN defined, stall_cnt SHALL count cycles with (mem_valid&&!mem_ready)||(mul_valid&&!mul_ready), saturating at all-ones.
REQ-029 With WB_STATS_EN defined, wb_cnt SHALL count cycles with wr_rd!=0, saturating at all-ones.
REQ-030 Without WB_STATS_EN, stall_cnt and wb_cnt SHALL be tied to 0, and no counter flops SHALL be inferred.

Structure
REQ-031 PARAMS_pkg SHALL hold WD_SIZE and INSTR_REG_BITS (existing), plus new enum wb_src_e and struct wb_req_t {rd, data}.
REQ-032 The FIFO SHALL be a sub-module wb_fifo (wb_req_t entries, push/pop/full/empty, async active-low reset).

Verification
REQ-033 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 1 -> wr_rd=5, wr_data=0xDEADBEEF, wr_src=WB_ALU in cycle 2; idle cycle 3 -> wr_rd=0.
REQ-034 Conflict: ALU rd=3 and MUL rd=7 valid with FIFO empty -> mul_ready=0, ALU written; next cycle with ALU idle -> MUL rd=7 written.
REQ-035 Round-robin: MEM rd=1,2 buffered, MUL rd=9 held valid, ALU idle -> write order 1, 9, 2 (rr starting at MEM).
REQ-036 FIFO full: 3 loads pushed back-to-back while ALU busy every cycle -> mem_ready=0 after 2 pushes, third held until a pop, no loss or reorder.
REQ-037 rd==0: ALU rd=0 with MEM head rd=4 -> MEM written in the same slot; MUL rd=0 accepted -> wr_rd=0.
REQ-038 Reset mid-stream with 2 FIFO entries -> outputs zero immediately, mem_ready=1, no stale writes; with WB_STATS_EN, counters restart from 0 and saturate at 0xFFFF.

Source files
------------

// File: rtl/PARAMS_pkg.sv
// rtl/PARAMS_pkg.sv - shared widths, write-back source enum and request/write-port structs
package PARAMS_pkg;

    localparam int WD_SIZE        = 32;
    localparam int INSTR_REG_BITS = 5;

    // Who owns the register-file write port in a given cycle
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_MUL  = 2'd3
    } wb_src_e;

    // Round-robin pointer between the load buffer and the multiplier
    typedef enum logic {
        RR_MEM = 1'b0,
        RR_MUL = 1'b1
    } rr_e;

    // One pending result: destination register and value
    typedef struct packed {
        logic [INSTR_REG_BITS-1:0] rd;
        logic [WD_SIZE-1:0]        data;
    } wb_req_t;

    // Contents of the registered write port
    typedef struct packed {
        logic [INSTR_REG_BITS-1:0] rd;
        logic [WD_SIZE-1:0]        data;
        wb_src_e                   src;
    } wr_port_t;

    localparam wr_port_t WR_IDLE = '{rd: '0, data: '0, src: WB_NONE};

    // A granted result aimed at x0 still uses its slot but must not write
    function automatic wr_port_t wb_slot(input wb_req_t req, input wb_src_e src);
        wr_port_t w;
        if (req.rd == '0) begin
            w = WR_IDLE;
        end else begin
            w.rd   = req.rd;
            w.data = req.data;
            w.src  = src;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small load-result buffer with occupancy counter
module wb_fifo
    import PARAMS_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    wb_req_t       store [DEPTH];

    logic do_push;
    logic do_pop;

    // Pointers alone cannot tell full from empty; the counter does
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Entry storage needs no reset: occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap at DEPTH; occupancy tracks push/pop balance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter (ALU > round-robin MEM/MUL); WB_STATS_EN adds stall/write counters
module wb_arbiter
    import PARAMS_pkg::*;
#(
    parameter int MEM_FIFO_DEPTH = 2,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alu_valid,
    input  logic [INSTR_REG_BITS-1:0] alu_rd,
    input  logic [WD_SIZE-1:0]        alu_data,
    input  logic                      mem_valid,
    input  logic [INSTR_REG_BITS-1:0] mem_rd,
    input  logic [WD_SIZE-1:0]        mem_data,
    output logic                      mem_ready,
    input  logic                      mul_valid,
    input  logic [INSTR_REG_BITS-1:0] mul_rd,
    input  logic [WD_SIZE-1:0]        mul_data,
    output logic                      mul_ready,
    output logic [INSTR_REG_BITS-1:0] wr_rd,
    output logic [WD_SIZE-1:0]        wr_data,
    output wb_src_e                   wr_src,
    output logic [STAT_WIDTH-1:0]     stall_cnt,
    output logic [STAT_WIDTH-1:0]     wb_cnt
);

    wb_req_t  mem_req;
    wb_req_t  fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    rr_e      rr;
    logic     alu_takes;
    logic     mul_grant;
    wr_port_t wr_next;

    assign mem_req = '{rd: mem_rd, data: mem_data};

    // Acceptance depends only on registered occupancy, so a pop never frees room the same cycle
    assign mem_ready = !fifo_full;
    assign fifo_push = mem_valid && !fifo_full;

    wb_fifo #(
        .DEPTH (MEM_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (mem_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Grant decisions: ALU first, then the head of the load buffer or the multiplier by rr
    always_comb begin
        alu_takes = alu_valid && (alu_rd != '0);
        mul_ready = !alu_takes && (fifo_empty || (rr == RR_MUL));
        fifo_pop  = !alu_takes && !fifo_empty && (!mul_valid || (rr == RR_MEM));
        mul_grant = mul_valid && mul_ready;
    end

    // Build next write-port contents from whichever source holds the slot
    always_comb begin
        wr_next = WR_IDLE;
        if (alu_takes) begin
            wr_next = wb_slot('{rd: alu_rd, data: alu_data}, WB_ALU);
        end else if (fifo_pop) begin
            wr_next = wb_slot(fifo_head, WB_MEM);
        end else if (mul_grant) begin
            wr_next = wb_slot('{rd: mul_rd, data: mul_data}, WB_MUL);
        end
    end

    // Register the write port; a grant in one cycle shows up only in the next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_rd   <= '0;
            wr_data <= '0;
            wr_src  <= WB_NONE;
        end else begin
            wr_rd   <= wr_next.rd;
            wr_data <= wr_next.data;
            wr_src  <= wr_next.src;
        end
    end

    // Round-robin pointer flips to the other source after any MEM or MUL grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr <= RR_MEM;
        end else if (fifo_pop) begin
            rr <= RR_MUL;
        end else if (mul_grant) begin
            rr <= RR_MEM;
        end
    end

`ifdef WB_STATS_EN
    logic stall_now;

    assign stall_now = (mem_valid && !mem_ready) || (mul_valid && !mul_ready);

    // Saturating counters: producer stall cycles and cycles with a real register write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            wb_cnt    <= '0;
        end else begin
            if (stall_now && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((wr_rd != '0) && (wb_cnt != '1)) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign wb_cnt    = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
    import PARAMS_pkg::*;

    localparam int DEPTH = 2;
    localparam int SW    = 4;
    localparam int SAT   = (1 << SW) - 1;

    logic                      clk;
    logic                      reset_n;
    logic                      alu_valid;
    logic [INSTR_REG_BITS-1:0] alu_rd;
    logic [WD_SIZE-1:0]        alu_data;
    logic                      mem_valid;
    logic [INSTR_REG_BITS-1:0] mem_rd;
    logic [WD_SIZE-1:0]        mem_data;
    logic                      mem_ready;
    logic                      mul_valid;
    logic [INSTR_REG_BITS-1:0] mul_rd;
    logic [WD_SIZE-1:0]        mul_data;
    logic                      mul_ready;
    logic [INSTR_REG_BITS-1:0] wr_rd;
    logic [WD_SIZE-1:0]        wr_data;
    wb_src_e                   wr_src;
    logic [SW-1:0]             stall_cnt;
    logic [SW-1:0]             wb_cnt;

    wb_arbiter #(
        .MEM_FIFO_DEPTH (DEPTH),
        .STAT_WIDTH     (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mul_valid (mul_valid),
        .mul_rd    (mul_rd),
        .mul_data  (mul_data),
        .mul_ready (mul_ready),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .stall_cnt (stall_cnt),
        .wb_cnt    (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    wb_req_t                   mq[$];
    bit                        next_is_mul;
    logic [INSTR_REG_BITS-1:0] exp_rd;
    logic [WD_SIZE-1:0]        exp_data;
    wb_src_e                   exp_src;
    int                        exp_stall;
    int                        exp_wb;
    logic                      s_mem_ready;
    logic                      s_mul_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        next_is_mul = 1'b0;
        exp_rd      = '0;
        exp_data    = '0;
        exp_src     = WB_NONE;
        exp_stall   = 0;
        exp_wb      = 0;
    endtask

    task automatic set_write(input logic [INSTR_REG_BITS-1:0] rd, input logic [WD_SIZE-1:0] d, input wb_src_e s);
        exp_rd   = rd;
        exp_data = (rd == 0) ? '0 : d;
        exp_src  = (rd == 0) ? WB_NONE : s;
    endtask

    // One clock: drive inputs, check readies against the model, clock, check the write port
    task automatic cyc(input logic av, input logic [INSTR_REG_BITS-1:0] ard, input logic [WD_SIZE-1:0] ad,
                       input logic mv, input logic [INSTR_REG_BITS-1:0] mrd, input logic [WD_SIZE-1:0] md,
                       input logic xv, input logic [INSTR_REG_BITS-1:0] xrd, input logic [WD_SIZE-1:0] xd);
        bit      room, has_entry, alu_wins, mul_ok, take_mem, stalled;
        wb_req_t h;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        mul_valid = xv; mul_rd = xrd; mul_data = xd;
        #1;
        room      = (mq.size() < DEPTH);
        has_entry = (mq.size() > 0);
        alu_wins  = av && (ard != 0);
        mul_ok    = !alu_wins && (!has_entry || next_is_mul);
        take_mem  = !alu_wins && has_entry && (!xv || !next_is_mul);
        s_mem_ready = mem_ready;
        s_mul_ready = mul_ready;
        check("mem_ready", mem_ready, room);
        check("mul_ready", mul_ready, mul_ok);
        stalled = (mv && !room) || (xv && !mul_ok);
        if (stalled && exp_stall < SAT) exp_stall++;
        if (exp_rd != 0 && exp_wb < SAT) exp_wb++;
        if (alu_wins) begin
            set_write(ard, ad, WB_ALU);
        end else if (take_mem) begin
            h = mq.pop_front();
            set_write(h.rd, h.data, WB_MEM);
            next_is_mul = 1'b1;
        end else if (xv && mul_ok) begin
            set_write(xrd, xd, WB_MUL);
            next_is_mul = 1'b0;
        end else begin
            set_write('0, '0, WB_NONE);
        end
        if (mv && room) mq.push_back('{rd: mrd, data: md});
        @(posedge clk);
        #1;
        check("wr_rd", wr_rd, exp_rd);
        check("wr_data", wr_data, exp_data);
        check("wr_src", wr_src, exp_src);
`ifdef WB_STATS_EN
        check("stall_cnt", stall_cnt, exp_stall);
        check("wb_cnt", wb_cnt, exp_wb);
`else
        check("stall_cnt", stall_cnt, 0);
        check("wb_cnt", wb_cnt, 0);
`endif
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        mul_valid = 0; mul_rd = '0; mul_data = '0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock
    task automatic reset_mid(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check({tag, "_wr_rd"}, wr_rd, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_src"}, wr_src, WB_NONE);
        check({tag, "_mem_ready"}, mem_ready, 1);
        check({tag, "_stall"}, stall_cnt, 0);
        check({tag, "_wb"}, wb_cnt, 0);
        idle_inputs();
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [INSTR_REG_BITS-1:0] rand_rd();
        return ($urandom_range(0, 3) == 0) ? '0 : INSTR_REG_BITS'($urandom);
    endfunction

    initial begin
        idle_inputs();
        model_clear();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_rd", wr_rd, 0);
        check("rst_wr_src", wr_src, WB_NONE);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_stall", stall_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU only
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        check("alu_rd", wr_rd, 5);
        check("alu_data", wr_data, 32'hDEADBEEF);
        check("alu_src", wr_src, WB_ALU);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_rd", wr_rd, 0);

        // ALU vs MUL conflict
        cyc(1, 3, 32'h33, 0, 0, 0, 1, 7, 32'h77);
        check("cf_mul_ready", s_mul_ready, 0);
        check("cf_alu_rd", wr_rd, 3);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 32'h77);
        check("cf_mul_rd", wr_rd, 7);
        check("cf_mul_src", wr_src, WB_MUL);

        // Round-robin MEM/MUL: order 1, 9, 2
        cyc(1, 20, 1, 1, 1, 32'h100, 0, 0, 0);
        cyc(1, 20, 1, 1, 2, 32'h200, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 32'h900);
        check("rr_first", wr_rd, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 32'h900);
        check("rr_second", wr_rd, 9);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 32'h900);
        check("rr_third", wr_rd, 2);

        // FIFO full while ALU busy, third load held
        cyc(1, 20, 1, 1, 11, 32'hB, 0, 0, 0);
        cyc(1, 20, 1, 1, 12, 32'hC, 0, 0, 0);
        cyc(1, 20, 1, 1, 13, 32'hD, 0, 0, 0);
        check("full_ready", s_mem_ready, 0);
        cyc(0, 0, 0, 1, 13, 32'hD, 0, 0, 0);
        check("full_ready_pop", s_mem_ready, 0);
        check("full_out1", wr_rd, 11);
        cyc(0, 0, 0, 1, 13, 32'hD, 0, 0, 0);
        check("full_ready_room", s_mem_ready, 1);
        check("full_out2", wr_rd, 12);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("full_out3", wr_rd, 13);
        check("full_data3", wr_data, 32'hD);

        // rd==0 handling
        cyc(1, 20, 1, 1, 4, 32'h44, 0, 0, 0);
        cyc(1, 0, 32'hBAD, 0, 0, 0, 0, 0, 0);
        check("rd0_mem_rd", wr_rd, 4);
        check("rd0_mem_src", wr_src, WB_MEM);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'h55);
        check("rd0_mul_ready", s_mul_ready, 1);
        check("rd0_mul_rd", wr_rd, 0);
        check("rd0_mul_src", wr_src, WB_NONE);

        // Reset with two buffered loads
        cyc(1, 20, 1, 1, 6, 32'h6, 0, 0, 0);
        cyc(1, 20, 1, 1, 7, 32'h7, 0, 0, 0);
        reset_mid("rst_mid");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("rst_no_stale", wr_rd, 0);
        end

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 800; i++) begin
            if (i == 400) reset_mid("rst_rand");
            cyc($urandom_range(0, 2) == 0, rand_rd(), $urandom,
                $urandom_range(0, 1) == 1, rand_rd(), $urandom,
                $urandom_range(0, 1) == 1, rand_rd(), $urandom);
        end

        // Counter saturation: restart, then stall the multiplier for many cycles
        reset_mid("rst_sat");
        for (int i = 0; i < 2 * SAT; i++) begin
            cyc(1, 21, 32'h1, 0, 0, 0, 1, 8, 32'h8);
        end
`ifdef WB_STATS_EN
        check("sat_stall", stall_cnt, SAT);
        check("sat_wb", wb_cnt, SAT);
`else
        check("off_stall", stall_cnt, 0);
        check("off_wb", wb_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
